// File: rtl/emesh_reg_master_pkg.sv
// Shared definitions for the emesh register master: FSM encoding, datamode
// constant and the bit positions of the emesh packet fields.
package emesh_reg_master_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   localparam logic [1:0] DATAMODE_32 = 2'b10;

   // Packet layout: write[0], datamode[2:1], ctrlmode[7:3], then dstaddr,
   // data and srcaddr as consecutive AW-wide fields.
   localparam int unsigned WR_BIT  = 0;
   localparam int unsigned DM_LSB  = 1;
   localparam int unsigned CM_LSB  = 3;
   localparam int unsigned DST_LSB = 8;

   function automatic int unsigned data_lsb(input int unsigned aw);
      return DST_LSB + aw;
   endfunction

   function automatic int unsigned src_lsb(input int unsigned aw);
      return DST_LSB + 2 * aw;
   endfunction

endpackage

// File: rtl/emesh_reg_master.sv
// Single-outstanding emesh register initiator: issues one write or read
// request at a time and returns completion, readback data or a read timeout.
module emesh_reg_master
   import emesh_reg_master_pkg::*;
#(
   parameter int unsigned    AW    = 32,
   parameter int unsigned    PW    = 104,
   parameter logic [AW-1:0]  SRCID = '0,
   parameter int unsigned    TW    = 8
) (
   input  logic          clk,
   input  logic          nreset,
   // Command side: a command transfers on a clock edge where cmd_valid and
   // cmd_ready are both high; rsp_valid is a one-cycle completion pulse.
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_data,
   output logic          rsp_valid,
   output logic          rsp_error,
   output logic [AW-1:0] rsp_data,
   // Mesh side: a request transfers on an edge with access_out=1, wait_in=0.
   output logic          access_out,
   output logic [PW-1:0] packet_out,
   input  logic          wait_in,
   input  logic          access_in,
   input  logic [PW-1:0] packet_in,
   output logic          wait_out,
   output state_t        o_dbg_state
);

   localparam int unsigned    DATA_LSB = data_lsb(AW);
   localparam int unsigned    SRC_LSB  = src_lsb(AW);
   localparam logic [TW-1:0]  TC       = '1;
   localparam logic [TW-1:0]  TC_M1    = TC - 1'b1;

   state_t          r_state;
   logic            r_access;
   logic [PW-1:0]   r_pkt;
   logic            r_rsp_valid;
   logic            r_rsp_error;
   logic [AW-1:0]   r_rsp_data;
   logic [TW-1:0]   r_cnt;

   logic [PW-1:0]   w_req_pkt;
   logic            w_rsp_write;
   logic [AW-1:0]   w_rsp_dst;
   logic [AW-1:0]   w_rsp_data;
   logic            w_match;
   logic            w_unused_pkt;

   always_comb begin
      w_req_pkt                         = '0;
      w_req_pkt[WR_BIT]                 = cmd_write;
      w_req_pkt[DM_LSB +: 2]            = DATAMODE_32;
      w_req_pkt[CM_LSB +: 5]            = 5'd0;
      w_req_pkt[DST_LSB +: AW]          = cmd_addr;
      w_req_pkt[DATA_LSB +: AW]         = cmd_write ? cmd_data : '0;
      w_req_pkt[SRC_LSB +: AW]          = SRCID;
   end

   // A readback is a write packet addressed back to our own source ID.
   assign w_rsp_write  = packet_in[WR_BIT];
   assign w_rsp_dst    = packet_in[DST_LSB +: AW];
   assign w_rsp_data   = packet_in[DATA_LSB +: AW];
   assign w_match      = access_in & w_rsp_write & (w_rsp_dst == SRCID);
   assign w_unused_pkt = ^{packet_in[PW-1:SRC_LSB], packet_in[DST_LSB-1:DM_LSB]};

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state     <= IDLE;
         r_access    <= 1'b0;
         r_pkt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_error <= 1'b0;
         r_rsp_data  <= '0;
         r_cnt       <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_pkt    <= w_req_pkt;
                  r_access <= 1'b1;
                  r_state  <= SEND;
               end
            end
            SEND: begin
               if (!wait_in) begin
                  r_access <= 1'b0;
                  if (r_pkt[WR_BIT]) begin
                     // Posted write: completion means the request was issued.
                     r_rsp_valid <= 1'b1;
                     r_rsp_error <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= WAIT_RSP;
                  end
               end
            end
            WAIT_RSP: begin
               if (w_match) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= 1'b0;
                  r_rsp_data  <= w_rsp_data;
                  r_state     <= IDLE;
               end else begin
                  if (r_cnt != TC) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
                  // Counter reaches terminal count on this edge.
                  if (r_cnt == TC_M1) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_error <= 1'b1;
                     r_rsp_data  <= '0;
                     r_state     <= IDLE;
                  end
               end
            end
            default: begin
               r_access <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = (r_state == IDLE);
   assign access_out  = r_access;
   assign packet_out  = r_pkt;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_error   = r_rsp_error;
   assign rsp_data    = r_rsp_data;
   assign wait_out    = 1'b0;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_emesh_reg_master.sv
// Randomized and directed bench for emesh_reg_master against a
// transaction-level model of request packets, completions and timeouts.
module tb_emesh_reg_master;
   import emesh_reg_master_pkg::*;

   localparam int          AW     = 32;
   localparam int          PW     = 104;
   localparam int          TW     = 4;
   localparam logic [31:0] SRCID  = 32'h0000_0A00;
   localparam int          T_WAIT = (1 << TW) - 1;

   logic          clk;
   logic          nreset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [AW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_error;
   logic [AW-1:0] rsp_data;
   logic          access_out;
   logic [PW-1:0] packet_out;
   logic          wait_in;
   logic          access_in;
   logic [PW-1:0] packet_in;
   logic          wait_out;
   state_t        dbg_state;

   int            n_checks;
   int            n_errors;
   logic [AW:0]   exp_q[$];

   emesh_reg_master #(.AW(AW), .PW(PW), .SRCID(SRCID), .TW(TW)) dut (
      .clk(clk), .nreset(nreset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
      .access_out(access_out), .packet_out(packet_out), .wait_in(wait_in),
      .access_in(access_in), .packet_in(packet_in), .wait_out(wait_out),
      .o_dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] req_model(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      return {SRCID, (wr ? data : 32'h0), addr, 5'b0, 2'b10, wr};
   endfunction

   function automatic logic [PW-1:0] mesh_pkt(input bit wr, input logic [31:0] dst, input logic [31:0] data);
      return {32'h0000_0000, data, dst, 5'b0, 2'b10, wr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command, then follows the request through the stall window.
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data, input int stall);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_data  = data;
      @(negedge clk);
      check_val("cmd_ready_idle", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      for (int s = 0; s <= stall; s++) begin
         wait_in = (s < stall);
         @(negedge clk);
         check_val("access_out_send", access_out, 1'b1);
         check_val("packet_out", packet_out, req_model(wr, addr, data));
         check_val("cmd_ready_busy", cmd_ready, 1'b0);
         tick();
      end
      wait_in = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int stall);
      issue(1'b1, addr, data, stall);
      @(negedge clk);
      check_val("wr_rsp_valid", rsp_valid, 1'b1);
      check_val("wr_rsp_error", rsp_error, 1'b0);
      check_val("wr_access_off", access_out, 1'b0);
      check_val("wr_cmd_ready", cmd_ready, 1'b1);
      tick();
      @(negedge clk);
      check_val("wr_rsp_pulse", rsp_valid, 1'b0);
      tick();
   endtask

   // resp_at: WAIT_RSP cycle (1-based) carrying the readback, 0 for none.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int resp_at,
                          input bit stray, input int stall);
      int got;
      int exp_cycle;
      logic [AW:0] exp_v;
      got       = 0;
      exp_cycle = (resp_at > 0) ? resp_at + 1 : T_WAIT + 1;
      exp_q.push_back((resp_at > 0) ? {1'b0, data} : {1'b1, 32'h0});
      issue(1'b0, addr, $urandom, stall);
      for (int k = 1; k <= T_WAIT + 4; k++) begin
         access_in = 1'b0;
         packet_in = mesh_pkt(1'b1, SRCID, $urandom);
         if (k == resp_at) begin
            access_in = 1'b1;
            packet_in = mesh_pkt(1'b1, SRCID, data);
         end else if (stray && (k % 2 == 1)) begin
            access_in = 1'b1;
            if ($urandom_range(0, 1) == 1)
               packet_in = mesh_pkt(1'b1, 32'h0000_0B00, $urandom);
            else
               packet_in = mesh_pkt(1'b0, SRCID, $urandom);
         end
         @(negedge clk);
         if (rsp_valid) begin
            got = k;
            break;
         end
         tick();
      end
      access_in = 1'b0;
      check_val("rd_rsp_cycle", got, exp_cycle);
      exp_v = exp_q.pop_front();
      if (got != 0) check_val("rd_rsp_err_data", {rsp_error, rsp_data}, exp_v);
      tick();
      @(negedge clk);
      check_val("rd_rsp_pulse", rsp_valid, 1'b0);
      check_val("rd_hold_data", {rsp_error, rsp_data}, exp_v);
      tick();
   endtask

   task automatic late_response();
      access_in = 1'b1;
      packet_in = mesh_pkt(1'b1, SRCID, $urandom);
      tick();
      access_in = 1'b0;
      @(negedge clk);
      check_val("late_rsp_ignored", rsp_valid, 1'b0);
      tick();
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      nreset    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      wait_in   = 1'b0;
      access_in = 1'b0;
      packet_in = '0;
      repeat (3) tick();
      @(negedge clk);
      check_val("rst_access_out", access_out, 1'b0);
      check_val("rst_packet_out", packet_out, '0);
      check_val("rst_rsp_valid", rsp_valid, 1'b0);
      check_val("rst_rsp_err_data", {rsp_error, rsp_data}, '0);
      check_val("rst_cmd_ready", cmd_ready, 1'b1);
      check_val("rst_state", dbg_state, IDLE);
      check_val("wait_out_tied", wait_out, 1'b0);
      tick();
      nreset = 1'b1;
      tick();

      // Directed cases from the basic scenarios.
      do_write(32'h0000_0008, 32'h00FF_00FF, 0);
      do_write(32'h0000_0020, 32'hDEAD_BEEF, 5);
      do_read(32'h0000_0010, 32'h1234_5678, 3, 1'b0, 0);
      do_read(32'h0000_0014, 32'h0, 0, 1'b0, 0);
      late_response();
      do_read(32'h0000_0018, 32'hCAFE_F00D, 2, 1'b0, 1);
      do_read(32'h0000_001C, 32'hA5A5_5A5A, 6, 1'b1, 0);
      do_read(32'h0000_0024, 32'h0BAD_C0DE, T_WAIT, 1'b0, 0);
      do_read(32'h0000_0028, 32'h1111_2222, 1, 1'b0, 2);
      late_response();

      // Back-to-back: second command accepted in the first's rsp_valid cycle.
      issue(1'b1, 32'h0000_0030, 32'h0000_0001, 0);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0034;
      cmd_data  = 32'h0000_0002;
      @(negedge clk);
      check_val("b2b_rsp_valid", rsp_valid, 1'b1);
      check_val("b2b_cmd_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      check_val("b2b_access_out", access_out, 1'b1);
      check_val("b2b_packet_out", packet_out, req_model(1'b1, 32'h0000_0034, 32'h0000_0002));
      tick();
      @(negedge clk);
      check_val("b2b_rsp2_valid", rsp_valid, 1'b1);
      tick();

      // Reset while stalled in SEND.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0040;
      cmd_data  = 32'h7777_8888;
      wait_in   = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check_val("pre_rst_send_access", access_out, 1'b1);
      #2 nreset = 1'b0;
      #1;
      check_val("rst_send_access_out", access_out, 1'b0);
      check_val("rst_send_packet_out", packet_out, '0);
      check_val("rst_send_rsp", {rsp_valid, rsp_error, rsp_data}, '0);
      check_val("rst_send_cmd_ready", cmd_ready, 1'b1);
      tick();
      wait_in = 1'b0;
      nreset  = 1'b1;
      tick();
      do_write(32'h0000_0044, 32'h1357_9BDF, 0);

      // Reset while waiting for a readback; the late readback is stray.
      issue(1'b0, 32'h0000_0048, 32'h0, 0);
      tick();
      tick();
      @(negedge clk);
      check_val("pre_rst_wait_ready", cmd_ready, 1'b0);
      #2 nreset = 1'b0;
      #1;
      check_val("rst_wait_access_out", access_out, 1'b0);
      check_val("rst_wait_rsp_valid", rsp_valid, 1'b0);
      check_val("rst_wait_cmd_ready", cmd_ready, 1'b1);
      tick();
      nreset = 1'b1;
      late_response();
      do_read(32'h0000_004C, 32'h2468_ACE0, 4, 1'b1, 0);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_write($urandom, $urandom, $urandom_range(0, 4));
         end else if ($urandom_range(0, 4) == 0) begin
            do_read($urandom, $urandom, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            late_response();
         end else begin
            do_read($urandom, $urandom, $urandom_range(1, T_WAIT), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
